// File: rtl/door_interlock_ctrl_if.sv
// door_interlock_ctrl_if: signal bundle between the mantrap controller and its environment.
//   door_sw   [1:0]  raw door limit switches (1 = door open)
//   req       [1:0]  raw entry request buttons (1 = pressed)
//   emergency        raw emergency release (1 = active)
//   alarm_clr        synchronous clear of the alarm state
//   pos1/pos2        servo pulse-width commands in clk counts
//   locked    [1:0]  1 = door commanded locked
//   state     [2:0]  current controller state code
//   alarm            high while in the alarm state
// master drives the raw inputs and observes the commands; slave is the controller.
interface door_interlock_ctrl_if #(
    parameter int POS_W = 18
);
    logic [1:0]       door_sw;
    logic [1:0]       req;
    logic             emergency;
    logic             alarm_clr;
    logic [POS_W-1:0] pos1;
    logic [POS_W-1:0] pos2;
    logic [1:0]       locked;
    logic [2:0]       state;
    logic             alarm;

    modport master (
        output door_sw, req, emergency, alarm_clr,
        input  pos1, pos2, locked, state, alarm
    );

    modport slave (
        input  door_sw, req, emergency, alarm_clr,
        output pos1, pos2, locked, state, alarm
    );
endinterface

// File: rtl/door_interlock_ctrl.sv
// door_interlock_ctrl: two-door mantrap interlock; at most one door unlocked at a time.
//   clk          system clock
//   rst          asynchronous active-high reset
//   bus (slave)  door_sw/req/emergency/alarm_clr in; pos1/pos2/locked/state/alarm out
// Door switches and requests are synchronized and debounced, emergency is only
// synchronized. Requests are captured into pending bits and granted round-robin.
module door_interlock_ctrl #(
    parameter int DEB_CYCLES = 120000,
    parameter int UNLOCK_TO  = 60000000,
    parameter int SETTLE_CYC = 6000000,
    parameter int POS_OPEN   = 27000,
    parameter int POS_LOCK   = 77000,
    parameter int POS_W      = 18
) (
    input logic clk,
    input logic rst,
    door_interlock_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UNLOCK1 = 3'd1,
        OPEN1   = 3'd2,
        UNLOCK2 = 3'd3,
        OPEN2   = 3'd4,
        SETTLE  = 3'd5,
        ALARM   = 3'd6,
        EMERG   = 3'd7
    } state_t;

    localparam int CW = $clog2(DEB_CYCLES + 1);

    state_t           state, state_n;
    logic [3:0]       sync1, sync2;
    logic             emg_s1, emg_s2;
    logic [3:0]       deb, deb_nx;
    logic [CW-1:0]    cnt [4];
    logic [1:0]       door_db, req_rise, pending, pend_n;
    logic             last_served;
    logic [31:0]      timer;
    logic             forced, pick2, enter_u1, enter_u2, open1, open2;
    logic [POS_W-1:0] pos1_q, pos2_q;
    logic [1:0]       locked_q;
    logic             alarm_q;

    // Bits [1:0] are the door switches, bits [3:2] the request buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            emg_s1 <= 1'b0;
            emg_s2 <= 1'b0;
        end else begin
            sync1  <= {bus.req, bus.door_sw};
            sync2  <= sync1;
            emg_s1 <= bus.emergency;
            emg_s2 <= emg_s1;
        end
    end

    // The FSM consumes the debouncer's next value so it reacts on the same
    // edge the debounced register changes.
    always_comb begin
        for (int i = 0; i < 4; i++)
            deb_nx[i] = (sync2[i] != deb[i] && cnt[i] == CW'(DEB_CYCLES - 1)) ? sync2[i] : deb[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            deb <= deb_nx;
            for (int i = 0; i < 4; i++)
                cnt[i] <= (sync2[i] == deb[i] || deb_nx[i] != deb[i]) ? '0 : cnt[i] + 1'b1;
        end
    end

    assign door_db  = deb_nx[1:0];
    assign req_rise = deb_nx[3:2] & ~deb[3:2];

    // A door open outside its own grant window is a forced entry.
    assign forced = (door_db[0] && state != UNLOCK1 && state != OPEN1) ||
                    (door_db[1] && state != UNLOCK2 && state != OPEN2);
    // Door 2 wins when it is the only request, or on a tie when door 1 was served last.
    assign pick2  = pending[1] && (!pending[0] || !last_served);

    always_comb begin
        state_n = state;
        if (emg_s2) state_n = EMERG;
        else if (state == EMERG) state_n = IDLE;
        else if (forced) state_n = ALARM;
        else begin
            case (state)
                IDLE:    if (pending != 2'b00 && door_db == 2'b00) state_n = pick2 ? UNLOCK2 : UNLOCK1;
                UNLOCK1: state_n = door_db[0] ? OPEN1 : (timer == 32'(UNLOCK_TO - 1) ? IDLE : UNLOCK1);
                OPEN1:   state_n = door_db[0] ? OPEN1 : SETTLE;
                UNLOCK2: state_n = door_db[1] ? OPEN2 : (timer == 32'(UNLOCK_TO - 1) ? IDLE : UNLOCK2);
                OPEN2:   state_n = door_db[1] ? OPEN2 : SETTLE;
                SETTLE:  state_n = (timer == 32'(SETTLE_CYC - 1)) ? IDLE : SETTLE;
                ALARM:   state_n = (bus.alarm_clr && door_db == 2'b00) ? IDLE : ALARM;
                default: state_n = state;
            endcase
        end
    end

    assign enter_u1 = state_n == UNLOCK1 && state != UNLOCK1;
    assign enter_u2 = state_n == UNLOCK2 && state != UNLOCK2;
    assign open1    = state_n == UNLOCK1 || state_n == OPEN1 || state_n == EMERG;
    assign open2    = state_n == UNLOCK2 || state_n == OPEN2 || state_n == EMERG;
    assign pend_n   = (state_n == EMERG) ? 2'b00 :
                      (pending | (state != EMERG ? req_rise : 2'b00)) & ~{enter_u2, enter_u1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            pending     <= '0;
            last_served <= 1'b1;
            pos1_q      <= POS_W'(POS_LOCK);
            pos2_q      <= POS_W'(POS_LOCK);
            locked_q    <= 2'b11;
            alarm_q     <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= (state_n != state) ? '0 :
                           (state == UNLOCK1 || state == UNLOCK2 || state == SETTLE) ? timer + 32'd1 : timer;
            pending     <= pend_n;
            last_served <= enter_u2 ? 1'b1 : (enter_u1 ? 1'b0 : last_served);
            pos1_q      <= open1 ? POS_W'(POS_OPEN) : POS_W'(POS_LOCK);
            pos2_q      <= open2 ? POS_W'(POS_OPEN) : POS_W'(POS_LOCK);
            locked_q    <= {~open2, ~open1};
            alarm_q     <= state_n == ALARM;
        end
    end

    assign bus.pos1   = pos1_q;
    assign bus.pos2   = pos2_q;
    assign bus.locked = locked_q;
    assign bus.state  = state;
    assign bus.alarm  = alarm_q;
endmodule

// File: tb/tb_door_interlock_ctrl.sv
// tb_door_interlock_ctrl: directed bench for the mantrap interlock controller.
module tb_door_interlock_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    door_interlock_ctrl_if #(.POS_W(18)) bus ();

    door_interlock_ctrl #(
        .DEB_CYCLES(4),
        .UNLOCK_TO(100),
        .SETTLE_CYC(20),
        .POS_OPEN(27000),
        .POS_LOCK(77000),
        .POS_W(18)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, output int n);
        n = 0;
        while (bus.state !== s && n < max) begin
            tick();
            n++;
        end
        if (bus.state !== s) n = -1;
    endtask

    task automatic do_reset();
        bus.door_sw   = 2'b00;
        bus.req       = 2'b00;
        bus.emergency = 1'b0;
        bus.alarm_clr = 1'b0;
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        bus.door_sw   = 2'b00;
        bus.req       = 2'b00;
        bus.emergency = 1'b0;
        bus.alarm_clr = 1'b0;
        rst = 1'b1;
        #2;
        total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
        total++; if (bus.pos1 !== 18'd77000 || bus.pos2 !== 18'd77000) begin bad++; $display("FAIL reset_pos got=%0d/%0d exp=77000/77000", bus.pos1, bus.pos2); end
        total++; if (bus.locked !== 2'b11) begin bad++; $display("FAIL reset_locked got=%b exp=11", bus.locked); end
        total++; if (bus.alarm !== 1'b0) begin bad++; $display("FAIL reset_alarm got=%b exp=0", bus.alarm); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int n;
        do_reset();
        bus.req = 2'b01;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 6) begin
                total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL single_early got=%0d exp=0", bus.state); end
            end
            if (i == 7) begin
                total++; if (bus.state !== 3'd1) begin bad++; $display("FAIL single_grant got=%0d exp=1", bus.state); end
                total++; if (bus.pos1 !== 18'd27000 || bus.pos2 !== 18'd77000) begin bad++; $display("FAIL single_unlock_pos got=%0d/%0d exp=27000/77000", bus.pos1, bus.pos2); end
                total++; if (bus.locked !== 2'b10) begin bad++; $display("FAIL single_unlock_locked got=%b exp=10", bus.locked); end
            end
        end
        bus.req = 2'b00;
        bus.door_sw = 2'b01;
        wait_state(3'd2, 20, n);
        total++; if (n !== 6) begin bad++; $display("FAIL single_open_latency got=%0d exp=6", n); end
        ticks(120);
        total++; if (bus.state !== 3'd2 || bus.pos1 !== 18'd27000) begin bad++; $display("FAIL single_open_hold got=%0d/%0d exp=2/27000", bus.state, bus.pos1); end
        bus.door_sw = 2'b00;
        wait_state(3'd5, 20, n);
        total++; if (n !== 6) begin bad++; $display("FAIL single_close_latency got=%0d exp=6", n); end
        total++; if (bus.pos1 !== 18'd77000 || bus.pos2 !== 18'd77000 || bus.locked !== 2'b11) begin bad++; $display("FAIL single_settle_out got=%0d/%0d/%b exp=77000/77000/11", bus.pos1, bus.pos2, bus.locked); end
        wait_state(3'd0, 40, n);
        total++; if (n !== 20) begin bad++; $display("FAIL single_settle_len got=%0d exp=20", n); end
    endtask

    task automatic test_timeout();
        int n;
        int seen;
        do_reset();
        bus.req = 2'b10;
        ticks(7);
        total++; if (bus.state !== 3'd3) begin bad++; $display("FAIL timeout_grant got=%0d exp=3", bus.state); end
        total++; if (bus.pos2 !== 18'd27000 || bus.locked !== 2'b01) begin bad++; $display("FAIL timeout_unlock got=%0d/%b exp=27000/01", bus.pos2, bus.locked); end
        bus.req = 2'b00;
        wait_state(3'd0, 200, n);
        total++; if (n !== 100) begin bad++; $display("FAIL timeout_len got=%0d exp=100", n); end
        total++; if (bus.pos2 !== 18'd77000) begin bad++; $display("FAIL timeout_relock got=%0d exp=77000", bus.pos2); end
        seen = 0;
        repeat (30) begin
            tick();
            if (bus.state !== 3'd0) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL timeout_pending got=%0d exp=0", seen); end
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        bus.req = 2'b11;
        ticks(7);
        total++; if (bus.state !== 3'd1) begin bad++; $display("FAIL rr_first got=%0d exp=1", bus.state); end
        ticks(3);
        bus.req = 2'b00;
        bus.door_sw = 2'b01;
        wait_state(3'd2, 20, n);
        bus.door_sw = 2'b00;
        wait_state(3'd5, 20, n);
        wait_state(3'd0, 40, n);
        wait_state(3'd3, 5, n);
        total++; if (n !== 1) begin bad++; $display("FAIL rr_second got=%0d exp=1", n); end
        wait_state(3'd0, 200, n);
        bus.req = 2'b11;
        ticks(7);
        total++; if (bus.state !== 3'd1) begin bad++; $display("FAIL rr_alternate got=%0d exp=1", bus.state); end
        bus.req = 2'b00;
    endtask

    task automatic test_forced();
        do_reset();
        bus.door_sw = 2'b10;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 5) begin
                total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL forced_early got=%0d exp=0", bus.state); end
            end
            if (i == 6) begin
                total++; if (bus.state !== 3'd6 || bus.alarm !== 1'b1) begin bad++; $display("FAIL forced_alarm got=%0d/%b exp=6/1", bus.state, bus.alarm); end
            end
        end
        bus.alarm_clr = 1'b1;
        tick();
        bus.alarm_clr = 1'b0;
        ticks(3);
        total++; if (bus.state !== 3'd6) begin bad++; $display("FAIL forced_clr_open got=%0d exp=6", bus.state); end
        bus.door_sw = 2'b00;
        ticks(8);
        total++; if (bus.state !== 3'd6) begin bad++; $display("FAIL forced_sticky got=%0d exp=6", bus.state); end
        bus.alarm_clr = 1'b1;
        tick();
        bus.alarm_clr = 1'b0;
        total++; if (bus.state !== 3'd0 || bus.alarm !== 1'b0) begin bad++; $display("FAIL forced_clear got=%0d/%b exp=0/0", bus.state, bus.alarm); end
    endtask

    task automatic test_emergency();
        int n;
        int seen;
        do_reset();
        bus.req = 2'b01;
        ticks(10);
        bus.req = 2'b00;
        bus.door_sw = 2'b01;
        wait_state(3'd2, 20, n);
        bus.req = 2'b10;
        ticks(10);
        bus.req = 2'b00;
        ticks(8);
        bus.emergency = 1'b1;
        ticks(3);
        total++; if (bus.state !== 3'd7) begin bad++; $display("FAIL emerg_enter got=%0d exp=7", bus.state); end
        total++; if (bus.pos1 !== 18'd27000 || bus.pos2 !== 18'd27000 || bus.locked !== 2'b00) begin bad++; $display("FAIL emerg_out got=%0d/%0d/%b exp=27000/27000/00", bus.pos1, bus.pos2, bus.locked); end
        bus.door_sw = 2'b11;
        ticks(10);
        total++; if (bus.state !== 3'd7 || bus.alarm !== 1'b0) begin bad++; $display("FAIL emerg_doors got=%0d/%b exp=7/0", bus.state, bus.alarm); end
        bus.door_sw = 2'b00;
        ticks(10);
        bus.emergency = 1'b0;
        ticks(3);
        total++; if (bus.state !== 3'd0 || bus.locked !== 2'b11) begin bad++; $display("FAIL emerg_exit got=%0d/%b exp=0/11", bus.state, bus.locked); end
        seen = 0;
        repeat (30) begin
            tick();
            if (bus.state !== 3'd0) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL emerg_pending got=%0d exp=0", seen); end
    endtask

    task automatic test_bounce_reset();
        int n;
        int seen;
        logic [4:0] k;
        do_reset();
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            k = 5'(i);
            bus.req = {1'b0, k[1]};
            tick();
            if (bus.state !== 3'd0) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL bounce_grant got=%0d exp=0", seen); end
        bus.req = 2'b01;
        wait_state(3'd1, 20, n);
        total++; if (n < 0) begin bad++; $display("FAIL bounce_settled_grant got=%0d exp=1", bus.state); end
        ticks(3);
        bus.req = 2'b00;
        #3;
        rst = 1'b1;
        #1;
        total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL midrst_state got=%0d exp=0", bus.state); end
        total++; if (bus.pos1 !== 18'd77000 || bus.pos2 !== 18'd77000 || bus.locked !== 2'b11) begin bad++; $display("FAIL midrst_out got=%0d/%0d/%b exp=77000/77000/11", bus.pos1, bus.pos2, bus.locked); end
        ticks(2);
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            tick();
            if (bus.state !== 3'd0) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midrst_idle got=%0d exp=0", seen); end
    endtask

    task automatic test_reset_open();
        do_reset();
        bus.door_sw = 2'b01;
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 5) begin
                total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL rstopen_early got=%0d exp=0", bus.state); end
            end
            if (i == 6) begin
                total++; if (bus.state !== 3'd6) begin bad++; $display("FAIL rstopen_alarm got=%0d exp=6", bus.state); end
            end
        end
        bus.door_sw = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single();
        test_timeout();
        test_round_robin();
        test_forced();
        test_emergency();
        test_bounce_reset();
        test_reset_open();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
